// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with bubble collapse and per-stage kill; PIPE_STAGE_CHAIN_OCC_EN adds an occupancy output
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic [DEPTH-1:0] flush_mask,
  output logic [DEPTH-1:0] stage_valid
`ifdef PIPE_STAGE_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
  logic [DEPTH-1:0] r_v, w_adv, w_up_v, w_nv;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [WIDTH-1:0] w_up_d [DEPTH];
  // A stage may advance unless it and every stage after it are full while the sink stalls
  always_comb begin
    w_up_v[0] = in_valid;
    w_up_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_up_v[k] = r_v[k-1];
      w_up_d[k] = r_d[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_adv[k] = out_ready | ~&(r_v | DEPTH'((1 << k) - 1));
      w_nv[k] = (w_adv[k] ? w_up_v[k] : r_v[k]) & ~flush_mask[k];
    end
  end
  assign in_ready = w_adv[0];
  assign out_valid = r_v[DEPTH-1];
  assign out_data = r_d[DEPTH-1];
  assign stage_valid = r_v;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
    end else begin
      r_v <= w_nv;
      for (int k = 0; k < DEPTH; k++) if (w_adv[k] && w_up_v[k]) r_d[k] <= w_up_d[k];
    end
`ifdef PIPE_STAGE_CHAIN_OCC_EN
  localparam int OW = $clog2(DEPTH+1);
  logic [OW-1:0] r_occ;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_occ <= '0;
    else r_occ <= OW'($countones(w_nv));
  assign occupancy = r_occ;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed checks of the DEPTH=3 chain and a DEPTH=1 WIDTH=8 instance
module tb_pipe_stage_chain;
  logic        clk = 0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [2:0]  flush_mask, stage_valid;
  logic        iv1, ir1, ov1, or1;
  logic [7:0]  id1, od1;
  logic [0:0]  fm1, sv1;
`ifdef PIPE_STAGE_CHAIN_OCC_EN
  logic [1:0]  occ;
  logic [0:0]  occ1;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] ivt = 8'b10110011;
  logic [7:0] ort = 8'b01101010;
  logic [7:0] irt = 8'b11111011;
  logic [7:0] ovt = 8'b10110111;
  logic [7:0] dt [8] = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h24, 8'h25, 8'h25, 8'h27};

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush_mask(flush_mask), .stage_valid(stage_valid)
`ifdef PIPE_STAGE_CHAIN_OCC_EN
    , .occupancy(occ)
`endif
  );

  pipe_stage_chain #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1),
    .out_ready(or1), .flush_mask(fm1), .stage_valid(sv1)
`ifdef PIPE_STAGE_CHAIN_OCC_EN
    , .occupancy(occ1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0; in_valid = 0; in_data = 0; out_ready = 1; flush_mask = 0;
    iv1 = 0; id1 = 0; or1 = 0; fm1 = 0;
    #1;
    check("rst_ov", out_valid, 0);
    check("rst_od", out_data, 0);
    check("rst_sv", stage_valid, 0);
    check("rst_ir", in_ready, 1);
    reset_n = 1;
    // streaming with out_ready high
    in_valid = 1; in_data = 32'hA0; tick;
    in_data = 32'hA1; tick;
    in_data = 32'hA2; #1 check("s_ir", in_ready, 1); tick;
    check("s_ov0", out_valid, 1); check("s_od0", out_data, 32'hA0);
    in_data = 32'hA3; tick;
    check("s_od1", out_data, 32'hA1);
    in_valid = 0; tick;
    check("s_od2", out_data, 32'hA2);
    tick;
    check("s_ov3", out_valid, 1); check("s_od3", out_data, 32'hA3);
    tick;
    check("s_empty", out_valid, 0);
    // fill against a stalled sink
    out_ready = 0;
    in_valid = 1; in_data = 32'hA0; tick;
    in_data = 32'hA1; tick;
    in_data = 32'hA2; tick;
    in_data = 32'hA3; #1;
    check("f_sv", stage_valid, 3'b111);
    check("f_ir", in_ready, 0);
`ifdef PIPE_STAGE_CHAIN_OCC_EN
    check("f_occ", occ, 3);
`endif
    tick;
    check("f_hold", out_data, 32'hA0);
    out_ready = 1; #1;
    check("f_ir_rise", in_ready, 1);
    tick;
    check("f_od1", out_data, 32'hA1);
    in_valid = 0; tick;
    check("f_od2", out_data, 32'hA2);
    tick;
    check("f_od3", out_data, 32'hA3);
    tick;
    check("f_empty", stage_valid, 0);
    // bubble collapse behind a stalled head
    out_ready = 0;
    in_valid = 1; in_data = 32'hB0; tick;
    in_valid = 0; tick; tick;
    check("b_sv0", stage_valid, 3'b100);
    in_valid = 1; in_data = 32'hB1; #1 check("b_ir1", in_ready, 1); tick;
    check("b_sv1", stage_valid, 3'b101);
    in_data = 32'hB2; #1 check("b_ir2", in_ready, 1); tick;
    check("b_sv2", stage_valid, 3'b111);
    in_valid = 0; #1 check("b_ir3", in_ready, 0);
    out_ready = 1; tick;
    check("b_od1", out_data, 32'hB1);
    tick;
    check("b_od2", out_data, 32'hB2);
    tick;
    check("b_empty", stage_valid, 0);
    // single-stage kill while streaming
    in_valid = 1; in_data = 32'hC0; tick;
    in_data = 32'hC1; tick;
    in_data = 32'hC2; flush_mask = 3'b010; tick;
    flush_mask = 0;
    check("k_sv", stage_valid, 3'b101);
    check("k_od0", out_data, 32'hC0);
    in_data = 32'hC3; tick;
    check("k_gap", out_valid, 0);
    in_data = 32'hC4; tick;
    check("k_od2", out_data, 32'hC2);
    in_data = 32'hC5; tick;
    check("k_od3", out_data, 32'hC3);
    in_valid = 0; tick;
    check("k_od4", out_data, 32'hC4);
    tick;
    check("k_ov5", out_valid, 1); check("k_od5", out_data, 32'hC5);
    tick;
    check("k_empty", out_valid, 0);
    // kill every stage together with an input handshake
    in_valid = 1; in_data = 32'hD0; tick;
    in_data = 32'hD1; tick;
    in_data = 32'hD2; flush_mask = 3'b111; #1 check("ka_ir0", in_ready, 1); tick;
    flush_mask = 0; in_valid = 0; #1;
    check("ka_sv", stage_valid, 0);
    check("ka_ir", in_ready, 1);
`ifdef PIPE_STAGE_CHAIN_OCC_EN
    check("ka_occ", occ, 0);
`endif
    tick;
    check("ka_sv2", stage_valid, 0);
    // asynchronous reset between edges
    in_valid = 1; in_data = 32'hE0; tick;
    in_data = 32'hE1; tick;
    in_data = 32'hE2; tick;
    check("r_pre", out_data, 32'hE0);
    in_valid = 0; #2 reset_n = 0; #1;
    check("r_ov", out_valid, 0);
    check("r_sv", stage_valid, 0);
    check("r_od", out_data, 0);
    @(negedge clk);
    reset_n = 1; in_valid = 1; in_data = 32'hF0; tick;
    in_valid = 0;
    check("r_sv1", stage_valid, 3'b001);
    tick;
    check("r_ov2", out_valid, 0);
    tick;
    check("r_ov3", out_valid, 1); check("r_od3", out_data, 32'hF0);
    tick;
    // DEPTH=1 instance with alternating out_ready
    for (int k = 0; k < 8; k++) begin
      iv1 = ivt[k]; or1 = ort[k]; id1 = 8'(8'h20 + k);
      #1 check($sformatf("d1_ir%0d", k), ir1, irt[k]);
      tick;
      check($sformatf("d1_ov%0d", k), ov1, ovt[k]);
      check($sformatf("d1_od%0d", k), od1, dt[k]);
`ifdef PIPE_STAGE_CHAIN_OCC_EN
      check($sformatf("d1_occ%0d", k), occ1, ovt[k]);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, elastic pipeline-register chain. Successor to the fixed IF/ID/ID-EX/EX-MEM/MEM-WB register bank.
- Carries a WIDTH-bit payload through DEPTH register stages.
- Uses valid/ready handshakes, bubble collapsing (a stalled head does not block empty stages behind it) and per-stage kill for branch/exception flush.
- Instantiated once per inter-stage boundary group in the core; any number of channels are packed into the payload.

Parameters:
- WIDTH, 32, payload bits per stage (>=1).
- DEPTH, 3, number of register stages (>=1). Stage 0 is input side, stage DEPTH-1 is output.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream offers payload
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  chain accepts payload this cycle
- out_valid  out  1  stage DEPTH-1 holds a valid entry
- out_data  out  WIDTH  stage DEPTH-1 payload
- out_ready  in  1  downstream consumes this cycle
- flush_mask  in  DEPTH  bit i kills the entry landing in/remaining in stage i at this edge
- stage_valid  out  DEPTH  per-stage valid bits (hazard/forwarding visibility)

Behaviour:
- Reset (async, reset_n=0): all stage valid bits =0, all stage data =0. Hence out_valid=0, out_data=0, stage_valid=0, in_ready=1. Release is synchronous to clk in the integrating design; the block needs no extra sync.
- Handshakes: transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
  - out_valid/out_data depend only on registers.
  - in_valid and in_data may change freely while in_ready=0. An item is accepted only on a handshake.
- Advance enable, combinational, computed from the tail backwards:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - adv[i] = !v[i] | adv[i+1]
  - in_ready = adv[0]
  - flush_mask does NOT affect adv/in_ready. No path from flush_mask to in_ready.
- Stage update at posedge clk:
  - If adv[i]: v[i] <= (i==0 ? in_valid : v[i-1]). d[i] <= upstream data only when the upstream valid is 1; otherwise d[i] holds.
  - Else v[i] and d[i] hold.
- Kill: after the update above, if flush_mask[i]=1 then v[i] <= 0; d[i] is don't-care and is held.
  - Kill of stage 0 with an input handshake: the item counts as accepted and is discarded.
  - Kill of stage DEPTH-1 does not cancel an output handshake in the same cycle; the current out_data was already consumed.
- Latency: an item accepted at edge N is presented at out_valid after edge N+DEPTH-1 (DEPTH cycles register-to-register with no stalls). Throughput is 1 item/cycle with out_ready held high.
- Bubble collapse: with out_ready=0 and v[DEPTH-1]=1, earlier empty stages still fill. in_ready falls only when all DEPTH stages are valid.
- Full chain with out_ready=1: in_ready=1 and every stage shifts in the same cycle. There is no dead cycle.
- Ordering: items leave in acceptance order. No duplication, no loss except via kill.
- DEPTH=1: single register. in_ready = !v[0] | out_ready.
- Reset mid-operation: all entries dropped immediately (async); no partial output.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_OCC_EN.
- Defined: adds output port occupancy, width $clog2(DEPTH+1).
  - Registered; reset 0.
  - After every edge it equals popcount(stage_valid), updated from next-state valid bits including kills (no lag).
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- DEPTH=3, WIDTH=32, out_ready=1. Send 0xA0,0xA1,0xA2,0xA3 on consecutive cycles from edge 1 → out_valid with 0xA0 after edge 3, then 0xA1..0xA3 on consecutive cycles; in_ready stays 1.
- out_ready=0, send 4 items → first 3 accepted, stage_valid=3'b111, in_ready=0, 4th held. Raise out_ready → 0xA0..0xA3 exit in order, none lost or duplicated.
- Bubble collapse: single item 0xB0 stalled in stage 2 (out_ready=0), stages 0-1 empty. Send 0xB1,0xB2 → both accepted on back-to-back cycles, stage_valid=3'b111.
- Flush: streaming 0xC0..0xC5 with out_ready=1, pulse flush_mask=3'b010 for one cycle → exactly the item entering stage 1 at that edge never appears at output; the remaining order is preserved. Also flush_mask=3'b111 with in handshake → chain empty next cycle, in_ready=1.
- Reset: assert reset_n=0 mid-stream between edges → out_valid, stage_valid, out_data go to 0 immediately. After release, a new item appears after DEPTH edges.
- DEPTH=1, WIDTH=8 with OCC_EN defined: alternate out_ready 1/0 → in_ready = !v|out_ready each cycle; occupancy tracks 0/1 exactly.
